// File: rtl/hybrid_counter_reader.sv
// Read side of the hybrid sync/ripple error counter: freezes the counter, double-samples
// a settled count, presents it on a valid/ready port and drains steps held while frozen.
module hybrid_counter_reader #(
    parameter int Width        = 41,
    parameter int SyncWidth    = 4,
    parameter int SettleCycles = 8,
    parameter int HoldWidth    = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SyncWidth-1:0] step_in,
    output logic [SyncWidth-1:0] step_out,
    input  logic [Width-1:0]     count_in,
    input  logic                 req,
    input  logic                 clr,
    output logic [Width-1:0]     snap,
    output logic                 snap_valid,
    input  logic                 snap_ready,
    output logic                 count_reset,
    output logic                 busy,
    output logic                 drop,
    output logic [2:0]           dbg_state,
    output logic [HoldWidth-1:0] dbg_hold
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FREEZE  = 3'd1,
        SAMP_A  = 3'd2,
        SAMP_B  = 3'd3,
        CMP     = 3'd4,
        PRESENT = 3'd5,
        CLEAR   = 3'd6
    } state_t;

    localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam int SumW = ((HoldWidth > SyncWidth) ? HoldWidth : SyncWidth) + 1;
    localparam logic [SumW-1:0] StepMax = SumW'((1 << SyncWidth) - 1);
    localparam logic [SumW-1:0] HoldMax = SumW'((1 << HoldWidth) - 1);

    state_t               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [Width-1:0]     a_q, a_d, b_q, b_d, snap_q, snap_d;
    logic                 clr_q, clr_d;
    logic [HoldWidth-1:0] hold_q, hold_d;
    logic                 drop_q, drop_d;
    logic                 count_reset_q;

    logic [SumW-1:0]      avail, residual;
    logic [SyncWidth-1:0] step_c;
    logic                 overflow;

    // Steps pass only in IDLE; anything not forwarded is banked in hold and drained later.
    always_comb begin
        avail = SumW'(hold_q) + SumW'(step_in);
        step_c = '0;
        if (state_q == IDLE) begin
            step_c = (avail > StepMax) ? StepMax[SyncWidth-1:0] : avail[SyncWidth-1:0];
        end
        residual = avail - SumW'(step_c);
        overflow = (residual > HoldMax);
        hold_d   = overflow ? HoldMax[HoldWidth-1:0] : residual[HoldWidth-1:0];
        drop_d   = drop_q;
        if (state_q == CLEAR) begin
            drop_d = 1'b0;
        end
        if (overflow) begin
            drop_d = 1'b1;
        end
    end

    // Snapshot port: a transfer happens on a cycle where snap_valid && snap_ready; snap
    // stays constant while snap_valid is high and keeps its value after the transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        snap_d  = snap_q;
        clr_d   = clr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req) begin
                    clr_d   = clr;
                    state_d = FREEZE;
                end
            end
            FREEZE: begin
                if (cnt_q == CntW'(SettleCycles - 1)) begin
                    state_d = SAMP_A;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            SAMP_A: begin
                a_d     = count_in;
                state_d = SAMP_B;
            end
            SAMP_B: begin
                b_d     = count_in;
                state_d = CMP;
            end
            CMP: begin
                if (a_q == b_q) begin
                    snap_d  = a_q;
                    state_d = PRESENT;
                end else begin
                    a_d     = b_q;
                    state_d = SAMP_B;
                end
            end
            PRESENT: begin
                if (snap_ready) begin
                    state_d = clr_q ? CLEAR : IDLE;
                end
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            snap_q        <= '0;
            clr_q         <= 1'b0;
            hold_q        <= '0;
            drop_q        <= 1'b0;
            count_reset_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            snap_q        <= snap_d;
            clr_q         <= clr_d;
            hold_q        <= hold_d;
            drop_q        <= drop_d;
            count_reset_q <= (state_d == CLEAR);
        end
    end

    assign step_out    = step_c;
    assign snap        = snap_q;
    assign snap_valid  = (state_q == PRESENT);
    assign count_reset = count_reset_q;
    assign busy        = (state_q != IDLE);
    assign drop        = drop_q;
    assign dbg_state   = state_q;
    assign dbg_hold    = hold_q;

endmodule

// File: tb/tb_hybrid_counter_reader.sv
// Directed bench for hybrid_counter_reader: a default instance and a HoldWidth=4 instance
// for saturation, clear-after-read and asynchronous reset.
module tb_hybrid_counter_reader;

    localparam int W  = 41;
    localparam int SW = 4;

    // ---- clock / reset ----
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req, clr, snap_ready;
    logic [SW-1:0] step_in, step_out;
    logic [W-1:0]  count_in, snap;
    logic          snap_valid, count_reset, busy, drop;
    logic [2:0]    dbg_state;
    logic [11:0]   dbg_hold;

    logic          s_rst, s_req, s_clr, s_ready;
    logic [SW-1:0] s_step_in, s_step_out;
    logic [W-1:0]  s_count_in, s_snap;
    logic          s_snap_valid, s_count_reset, s_busy, s_drop;
    logic [2:0]    s_state;
    logic [3:0]    s_hold;

    hybrid_counter_reader u_dut (
        .clk(clk), .reset(rst), .step_in(step_in), .step_out(step_out),
        .count_in(count_in), .req(req), .clr(clr), .snap(snap),
        .snap_valid(snap_valid), .snap_ready(snap_ready), .count_reset(count_reset),
        .busy(busy), .drop(drop), .dbg_state(dbg_state), .dbg_hold(dbg_hold)
    );

    hybrid_counter_reader #(.HoldWidth(4)) u_small (
        .clk(clk), .reset(s_rst), .step_in(s_step_in), .step_out(s_step_out),
        .count_in(s_count_in), .req(s_req), .clr(s_clr), .snap(s_snap),
        .snap_valid(s_snap_valid), .snap_ready(s_ready), .count_reset(s_count_reset),
        .busy(s_busy), .drop(s_drop), .dbg_state(s_state), .dbg_hold(s_hold)
    );

    // ---- scoreboard ----
    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];
    int total;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---- driver tasks ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; clr = 1'b0; snap_ready = 1'b0;
        step_in = '0; count_in = '0;
        s_rst = 1'b1; s_req = 1'b0; s_clr = 1'b0; s_ready = 1'b0;
        s_step_in = '0; s_count_in = '0;
        repeat (3) tick();
        rst = 1'b0; s_rst = 1'b0;
        tick();

        // reset state
        check("rst_snap",       64'(snap), 64'h0);
        check("rst_valid",      64'(snap_valid), 64'h0);
        check("rst_count_rst",  64'(count_reset), 64'h0);
        check("rst_drop",       64'(drop), 64'h0);
        check("rst_busy",       64'(busy), 64'h0);
        check("rst_hold",       64'(dbg_hold), 64'h0);
        check("rst_s_valid",    64'(s_snap_valid), 64'h0);

        // passthrough
        for (int i = 0; i < 10; i++) begin
            step_in = 4'd3;
            exp_q.push_back(64'd3);
            #1;
            check("pass_step", 64'(step_out), exp_q.pop_front());
            tick();
        end
        check("pass_hold", 64'(dbg_hold), 64'h0);
        check("pass_busy", 64'(busy), 64'h0);
        step_in = '0;

        // snapshot of a static count, S=8
        count_in = 41'h123;
        req = 1'b1;
        #1;
        tick();
        req = 1'b0;
        step_in = 4'd3;
        #1;
        check("frz_step_zero", 64'(step_out), 64'h0);
        check("frz_busy",      64'(busy), 64'h1);
        step_in = '0;
        repeat (10) tick();
        check("snap_t11_valid", 64'(snap_valid), 64'h0);
        tick();
        check("snap_t12_valid", 64'(snap_valid), 64'h1);
        check("snap_value",     64'(snap), 64'h123);
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        check("snap_done_busy",  64'(busy), 64'h0);
        check("snap_done_valid", 64'(snap_valid), 64'h0);
        check("snap_kept",       64'(snap), 64'h123);

        // hold and drain
        req = 1'b1;
        #1;
        tick();
        req = 1'b0;
        step_in = 4'd15;
        repeat (11) tick();
        check("hold_present", 64'(snap_valid), 64'h1);
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        step_in = '0;
        #1;
        check("hold_180", 64'(dbg_hold), 64'd180);
        check("hold_idle", 64'(busy), 64'h0);
        total = 0;
        for (int i = 0; i < 12; i++) begin
            check("drain_step", 64'(step_out), 64'd15);
            total += int'(step_out);
            tick();
        end
        check("drain_end_step", 64'(step_out), 64'h0);
        check("drain_end_hold", 64'(dbg_hold), 64'h0);
        check("drain_total",    64'(total), 64'd180);

        // unstable count: value moves between the two samples
        count_in = 41'h0AA;
        req = 1'b1;
        #1;
        tick();
        req = 1'b0;
        repeat (8) tick();
        check("unst_samp_a", 64'(dbg_state), 64'd2);
        tick();
        count_in = 41'h0BB;
        repeat (2) tick();
        check("unst_retry_state", 64'(dbg_state), 64'd3);
        check("unst_no_valid",    64'(snap_valid), 64'h0);
        repeat (2) tick();
        check("unst_valid", 64'(snap_valid), 64'h1);
        check("unst_snap",  64'(snap), 64'h0BB);
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        check("unst_idle", 64'(busy), 64'h0);
        check("main_drop", 64'(drop), 64'h0);

        // saturation then clear-after-read (HoldWidth=4)
        s_count_in = 41'h55;
        s_req = 1'b1; s_clr = 1'b1;
        #1;
        tick();
        s_req = 1'b0; s_clr = 1'b0;
        s_step_in = 4'd15;
        tick();
        check("sat_hold_first", 64'(s_hold), 64'd15);
        check("sat_drop_first", 64'(s_drop), 64'h0);
        tick();
        check("sat_hold", 64'(s_hold), 64'd15);
        check("sat_drop", 64'(s_drop), 64'h1);
        s_step_in = '0;
        repeat (9) tick();
        check("clr_present", 64'(s_snap_valid), 64'h1);
        check("clr_snap",    64'(s_snap), 64'h55);
        check("clr_pre_pulse", 64'(s_count_reset), 64'h0);
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        check("clr_pulse",      64'(s_count_reset), 64'h1);
        check("clr_state",      64'(s_state), 64'd6);
        tick();
        check("clr_pulse_end",  64'(s_count_reset), 64'h0);
        check("clr_drop_clear", 64'(s_drop), 64'h0);
        check("clr_idle",       64'(s_busy), 64'h0);
        check("clr_hold_kept",  64'(s_hold), 64'd15);
        check("clr_drain",      64'(s_step_out), 64'd15);
        tick();
        check("clr_drained", 64'(s_hold), 64'h0);

        // asynchronous reset while presenting
        s_req = 1'b1;
        #1;
        tick();
        s_req = 1'b0;
        s_step_in = 4'd15;
        repeat (2) tick();
        check("ar_drop_set", 64'(s_drop), 64'h1);
        s_step_in = '0;
        repeat (9) tick();
        check("ar_present", 64'(s_snap_valid), 64'h1);
        #2;
        s_rst = 1'b1;
        #1;
        check("ar_valid", 64'(s_snap_valid), 64'h0);
        check("ar_hold",  64'(s_hold), 64'h0);
        check("ar_drop",  64'(s_drop), 64'h0);
        check("ar_busy",  64'(s_busy), 64'h0);
        check("ar_snap",  64'(s_snap), 64'h0);
        tick();
        s_rst = 1'b0;
        tick();

        // ---- report ----
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
